rev_host: RTL and testbench

Initiator for the digit-reversal core's start/Done handshake. Accepts operands from an upstream valid/ready source, holds `rv_start` and the operand steady while the reverser runs, and completes a full 4-phase handshake (start↑, done↑, start↓, done↓). It captures the reversed result and presents it downstream with valid/ready and an error flag. Sits between the system bus/host logic and the reverser datapath and controller.

---
 rtl/rev_host.sv | 199 +++++++++++++++++++
 tb/tb_rev_host.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rev_host.sv
// rev_host -- initiator for the digit-reversal core's start/done handshake.
// Takes one operand from a valid/ready source and drives rv_start/rv_x through a
// full 4-phase handshake (start up, done up, start down, done down). It then
// presents the reversed result downstream with valid/ready and an error flag.
// Optional feature macro: REV_HOST_TIMEOUT_EN. When it is defined, a REQ-phase
// timeout counter is built and out_err reports expiry. When it is undefined,
// REQ waits indefinitely and out_err is tied low.
module rev_host #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   input  logic             out_ready,
   output logic             rv_start,
   output logic [WIDTH-1:0] rv_x,
   input  logic             rv_done,
   input  logic [WIDTH-1:0] rv_result,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             rv_start_q, rv_start_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] rv_x_q, rv_x_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             accept_s;
   logic             rel_exit_s;
   logic             tmo_s;
   logic             err_s;
   logic             in_ready_s;
   logic             busy_s;

   // An operand is taken only from IDLE; the result is captured when REL sees done low,
   // because the reverser loads its output register on the edge REQ sees done.
   assign accept_s   = (state_q == ST_IDLE) && in_valid;
   assign rel_exit_s = (state_q == ST_REL) && !rv_done;

`ifdef REV_HOST_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          out_err_q, out_err_d;

   // Expiry only counts when done is absent on that edge: a coincident done wins.
   assign tmo_s = (state_q == ST_REQ) && !rv_done && (cnt_q == CW'(TIMEOUT - 1));
   assign err_s = err_q;

   // Timeout bookkeeping: count REQ cycles, latch the error and hand it to the output flag.
   always_comb begin
      cnt_d     = cnt_q;
      err_d     = err_q;
      out_err_d = out_err_q;
      if (accept_s) begin
         cnt_d = {CW{1'b0}};
         err_d = 1'b0;
      end else if (tmo_s) begin
         err_d = 1'b1;
      end else if ((state_q == ST_REQ) && !rv_done) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
      if (rel_exit_s) begin
         out_err_d = err_q;
      end else begin
         out_err_d = out_err_q;
      end
   end

   // Timeout counter, sticky error and registered error output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= {CW{1'b0}};
         err_q     <= 1'b0;
         out_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         out_err_q <= out_err_d;
      end
   end

   assign out_err = out_err_q;
`else
   assign tmo_s   = 1'b0;
   assign err_s   = 1'b0;
   assign out_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for the 4-phase handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) state_d = ST_REQ;
            else          state_d = ST_IDLE;
         end
         ST_REQ: begin
            if (rv_done || tmo_s) state_d = ST_REL;
            else                  state_d = ST_REQ;
         end
         ST_REL: begin
            if (!rv_done) state_d = ST_OUT;
            else          state_d = ST_REL;
         end
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
            else           state_d = ST_OUT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs: the upstream ready and the busy flag.
   always_comb begin
      in_ready_s = 1'b0;
      busy_s     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b0;
         end
         ST_REQ, ST_REL, ST_OUT: begin
            in_ready_s = 1'b0;
            busy_s     = 1'b1;
         end
         default: begin
            in_ready_s = 1'b0;
            busy_s     = 1'b1;
         end
      endcase
   end

   // Next values for the operand/result registers and the registered strobes.
   always_comb begin
      rv_x_d      = rv_x_q;
      out_data_d  = out_data_q;
      rv_start_d  = (state_d == ST_REQ);
      out_valid_d = (state_d == ST_OUT);
      if (accept_s) begin
         rv_x_d = in_data;
      end else begin
         rv_x_d = rv_x_q;
      end
      if (rel_exit_s) begin
         if (err_s) out_data_d = {WIDTH{1'b0}};
         else       out_data_d = rv_result;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Registered, glitch-free outputs; values hold outside their qualifying states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_start_q  <= 1'b0;
         out_valid_q <= 1'b0;
         rv_x_q      <= {WIDTH{1'b0}};
         out_data_q  <= {WIDTH{1'b0}};
      end else begin
         rv_start_q  <= rv_start_d;
         out_valid_q <= out_valid_d;
         rv_x_q      <= rv_x_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign busy      = busy_s;
   assign rv_start  = rv_start_q;
   assign out_valid = out_valid_q;
   assign rv_x      = rv_x_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_rev_host.sv
// tb_rev_host -- directed bench for rev_host with a behavioural digit reverser,
// a transaction-level expectation model and a per-cycle compare process.
module tb_rev_host;
   localparam int W  = 16;
   localparam int TO = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_err;
   logic         out_ready;
   logic         rv_start;
   logic [W-1:0] rv_x;
   logic         rv_done;
   logic [W-1:0] rv_result;
   logic         busy;

   int checks;
   int errors;

   // reverser model controls
   int   rv_lat;
   int   rv_hold;
   logic rv_dead;
   int   rcnt;
   int   hcnt;

   // expectation model
   logic         m_req, m_rel, m_out, m_err, e_err;
   logic [W-1:0] e_x, e_data;
   int           m_len;

   rev_host #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_ready (out_ready),
      .rv_start  (rv_start),
      .rv_x      (rv_x),
      .rv_done   (rv_done),
      .rv_result (rv_result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] rev_dec(input logic [W-1:0] v);
      int x;
      int r;
      x = int'(v);
      r = 0;
      while (x > 0) begin
         r = r * 10 + (x % 10);
         x = x / 10;
      end
      return W'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reverser: done after rv_lat REQ cycles, held rv_hold extra cycles after start drops.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_done   <= 1'b0;
         rv_result <= '0;
         rcnt      <= 0;
         hcnt      <= 0;
      end else if (rv_start) begin
         hcnt <= 0;
         rcnt <= rcnt + 1;
         if (!rv_dead && (rcnt + 1 == rv_lat - 1)) begin
            rv_done   <= 1'b1;
            rv_result <= rev_dec(rv_x);
         end
      end else begin
         rcnt <= 0;
         if (rv_done) begin
            hcnt <= hcnt + 1;
            if (hcnt >= rv_hold) rv_done <= 1'b0;
         end else begin
            hcnt <= 0;
         end
      end
   end

   // Expectation model: one transaction in flight, tracked by handshake events.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_req <= 1'b0; m_rel <= 1'b0; m_out <= 1'b0; m_err <= 1'b0;
         e_err <= 1'b0; e_x <= '0; e_data <= '0; m_len <= 0;
      end else if (m_req) begin
         m_len <= m_len + 1;
         if (rv_done) begin
            m_req <= 1'b0; m_rel <= 1'b1; m_err <= 1'b0;
         end
`ifdef REV_HOST_TIMEOUT_EN
         else if (m_len + 1 == TO) begin
            m_req <= 1'b0; m_rel <= 1'b1; m_err <= 1'b1;
         end
`endif
      end else if (m_rel) begin
         if (!rv_done) begin
            m_rel  <= 1'b0;
            m_out  <= 1'b1;
            e_err  <= m_err;
            e_data <= m_err ? '0 : rev_dec(e_x);
         end
      end else if (m_out) begin
         if (out_ready) m_out <= 1'b0;
      end else if (in_valid) begin
         m_req <= 1'b1; e_x <= in_data; m_len <= 0; m_err <= 1'b0;
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      chk("in_ready",  32'(in_ready),  32'(!(m_req || m_rel || m_out)));
      chk("busy",      32'(busy),      32'(m_req || m_rel || m_out));
      chk("rv_start",  32'(rv_start),  32'(m_req));
      chk("out_valid", 32'(out_valid), 32'(m_out));
      chk("rv_x",      32'(rv_x),      32'(e_x));
      chk("out_data",  32'(out_data),  32'(e_data));
      chk("out_err",   32'(out_err),   32'(e_err));
   end

   task automatic start_op(input logic [W-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 400) begin
         step();
         n++;
      end
      chk("accept_seen", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int sc, output logic [W-1:0] d, output logic e);
      int n;
      sc = 0;
      n  = 0;
      while (!out_valid && n < 400) begin
         if (rv_start) sc++;
         step();
         n++;
      end
      chk("result_seen", 32'(out_valid), 32'd1);
      d = out_data;
      e = out_err;
   endtask

   task automatic release_out(input int bp, input logic stray, input logic [W-1:0] sd);
      out_ready = 1'b0;
      if (stray) begin
         in_valid = 1'b1;
         in_data  = sd;
      end
      repeat (bp) step();
      chk("out_in_ready_low", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] d;
      logic         e;
      int           sc;
      checks = 0; errors = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      rv_lat = 5; rv_hold = 0; rv_dead = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rv_start",  32'(rv_start),  32'd0);
      chk("rst_rv_x",      32'(rv_x),      32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_err",   32'(out_err),   32'd0);
      rst = 1'b0;
      step();

      // basic
      rv_lat = 5;
      start_op(16'd12345);
      wait_result(sc, d, e);
      chk("basic_start_cycles", 32'(sc), 32'd5);
      chk("basic_data", 32'(d), 32'd54321);
      chk("basic_err",  32'(e), 32'd0);
      release_out(0, 1'b0, 16'd0);

      // trailing zero and zero operand
      rv_lat = 2;
      start_op(16'd1230);
      wait_result(sc, d, e);
      chk("tz_data", 32'(d), 32'd321);
      release_out(0, 1'b0, 16'd0);
      start_op(16'd0);
      wait_result(sc, d, e);
      chk("zero_data", 32'(d), 32'd0);
      release_out(0, 1'b0, 16'd0);

      // backpressure with a pending operand presented during OUT
      rv_lat = 3;
      start_op(16'd205);
      wait_result(sc, d, e);
      chk("bp_data_first", 32'(d), 32'd502);
      release_out(10, 1'b1, 16'd910);
      chk("bp_data_held", 32'(d), 32'(out_data));
      chk("bp_next_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_rv_x", 32'(rv_x), 32'd910);
      chk("bp_next_start", 32'(rv_start), 32'd1);
      wait_result(sc, d, e);
      chk("bp_next_data", 32'(d), 32'd19);
      release_out(0, 1'b0, 16'd0);

      // handshake order: done lingers after start drops
      rv_lat = 4; rv_hold = 3;
      start_op(16'd4321);
      wait_result(sc, d, e);
      chk("hs_start_cycles", 32'(sc), 32'd4);
      chk("hs_done_low", 32'(rv_done), 32'd0);
      chk("hs_data", 32'(d), 32'd1234);
      release_out(0, 1'b0, 16'd0);
      rv_hold = 0;

      // done arrives on the edge where the counter would expire
      rv_lat = TO;
      start_op(16'd56);
      wait_result(sc, d, e);
      chk("edge_start_cycles", 32'(sc), 32'(TO));
      chk("edge_data", 32'(d), 32'd65);
      chk("edge_err",  32'(e), 32'd0);
      release_out(0, 1'b0, 16'd0);

`ifdef REV_HOST_TIMEOUT_EN
      // reverser never answers
      rv_dead = 1'b1;
      start_op(16'd777);
      wait_result(sc, d, e);
      chk("tmo_start_cycles", 32'(sc), 32'd8);
      chk("tmo_data", 32'(d), 32'd0);
      chk("tmo_err",  32'(e), 32'd1);
      release_out(0, 1'b0, 16'd0);
      rv_dead = 1'b0;
`endif

      // back-to-back operand with out_ready already high: one valid cycle
      rv_lat = 3;
      out_ready = 1'b1;
      start_op(16'd42);
      wait_result(sc, d, e);
      chk("b2b_data", 32'(d), 32'd24);
      chk("b2b_err",  32'(e), 32'd0);
      step();
      chk("b2b_one_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // asynchronous reset three cycles into REQ
      rv_lat = 20;
      start_op(16'd333);
      step(); step(); step();
      rst = 1'b1;
      #1;
      chk("arst_rv_start",  32'(rv_start),  32'd0);
      chk("arst_busy",      32'(busy),      32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_rv_x",      32'(rv_x),      32'd0);
      step();
      rst = 1'b0;
      step();
      chk("arst_ready_after", 32'(in_ready), 32'd1);
      rv_lat = 3;
      start_op(16'd120);
      wait_result(sc, d, e);
      chk("arst_fresh_data", 32'(d), 32'd21);
      release_out(0, 1'b0, 16'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
